// File: rtl/mult_chk_pkg.sv
// Shared constants and helpers for the multiplier result checker.
package mult_chk_pkg;

  localparam int unsigned CHECK_CNT_W = 32;
  localparam int unsigned MISM_CNT_W  = 16;
  localparam int unsigned HOLD_CNT_W  = 16;
  localparam int unsigned DIST_SUM_W  = 48;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mult_result_checker_if.sv
// Multiplier-side signals observed by the checker: enable, operands and product.
interface mult_chk_if #(
  parameter int WIDTH = 16
);
  logic               en;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] Y;

  modport master (output en, A, B, Y);
  modport slave  (input  en, A, B, Y);
endinterface

// File: rtl/mult_chk_pipe.sv
// LAT-deep delay line of {valid, a, b} tracking operands in flight through the multiplier.
module mult_chk_pipe #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  logic [LAT-1:0]   vld_q;
  logic [WIDTH-1:0] a_q [LAT];
  logic [WIDTH-1:0] b_q [LAT];

  // NOTE: non-blocking assignments let every stage read its neighbour's old value, so the shift is order-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // NOTE: only the valid bits are reset; the operand storage is meaningless while invalid and stays reset-free.
  always_ff @(posedge clk) begin
    a_q[0] <= in_a;
    b_q[0] <= in_b;
    for (int i = 1; i < LAT; i++) begin
      a_q[i] <= a_q[i-1];
      b_q[i] <= b_q[i-1];
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_a     = a_q[LAT-1];
  assign out_b     = b_q[LAT-1];

endmodule

// File: rtl/mult_result_checker.sv
// On-chip checker for a clock-gated multiplier: compares Y with the exact product LAT cycles after capture.
// Optional MULT_CHK_ERR_DIST_EN adds error-distance sum/max outputs for approximate multipliers.
module mult_result_checker
  import mult_chk_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_chk_if.slave              bus,
  input  logic                   clr,
  output logic [CHECK_CNT_W-1:0] check_count,
  output logic [MISM_CNT_W-1:0]  mismatch_count,
  output logic [HOLD_CNT_W-1:0]  hold_viol_count,
  output logic                   err_sticky,
  output logic                   first_err_valid,
  output logic [WIDTH-1:0]       first_err_a,
  output logic [WIDTH-1:0]       first_err_b,
`ifdef MULT_CHK_ERR_DIST_EN
  output logic [DIST_SUM_W-1:0]  err_dist_sum,
  output logic [2*WIDTH-1:0]     err_dist_max,
`endif
  output logic [2*WIDTH-1:0]     first_err_y
);

  localparam int PW = 2 * WIDTH;

  logic             p_valid;
  logic [WIDTH-1:0] p_a;
  logic [WIDTH-1:0] p_b;
  logic [PW-1:0]    exact_y;
  logic [PW-1:0]    ref_y;
  logic             is_cmp;
  logic             is_mism;
  logic             is_hold;

  mult_chk_pipe #(.WIDTH(WIDTH), .LAT(LAT)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.en),
    .in_a      (bus.A),
    .in_b      (bus.B),
    .out_valid (p_valid),
    .out_a     (p_a),
    .out_b     (p_b)
  );

  assign exact_y = PW'(p_a) * PW'(p_b);
  assign is_cmp  = p_valid;
  assign is_mism = is_cmp && (bus.Y != exact_y);
  assign is_hold = !is_cmp && (bus.Y != ref_y);

  // ref_y tracks the last accepted Y; clr leaves it alone so hold checking stays coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_y <= '0;
    end else if (is_cmp || is_hold) begin
      ref_y <= bus.Y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      check_count     <= '0;
      mismatch_count  <= '0;
      hold_viol_count <= '0;
      err_sticky      <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_y     <= '0;
    end else begin
      if (is_cmp)  check_count     <= sat_inc(check_count, CHECK_CNT_W);
      if (is_mism) mismatch_count  <= MISM_CNT_W'(sat_inc(32'(mismatch_count), MISM_CNT_W));
      if (is_hold) hold_viol_count <= HOLD_CNT_W'(sat_inc(32'(hold_viol_count), HOLD_CNT_W));
      if (is_mism || is_hold) err_sticky <= 1'b1;
      if (is_mism && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_a     <= p_a;
        first_err_b     <= p_b;
        first_err_y     <= bus.Y;
      end
    end
  end

`ifdef MULT_CHK_ERR_DIST_EN
  logic [PW-1:0]         dist;
  logic [DIST_SUM_W:0]   sum_ext;

  assign dist    = (bus.Y >= exact_y) ? (bus.Y - exact_y) : (exact_y - bus.Y);
  assign sum_ext = {1'b0, err_dist_sum} + (DIST_SUM_W + 1)'(dist);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_dist_sum <= '0;
      err_dist_max <= '0;
    end else if (is_cmp) begin
      err_dist_sum <= sum_ext[DIST_SUM_W] ? '1 : sum_ext[DIST_SUM_W-1:0];
      if (dist > err_dist_max) err_dist_max <= dist;
    end
  end
`endif

endmodule
